// File: rtl/detect_event_logger_if.sv
// Handshake bundle between detect_event_logger and its detector/readout neighbours.
// drop_cnt is present only when DETECT_LOG_DROP_CNT_EN is defined.
interface detect_event_logger_if #(
  parameter int TS_W  = 16,
  parameter int CNT_W = 8
);
  logic             det;
  logic             out_valid;
  logic             out_ready;
  logic [TS_W-1:0]  out_ts;
  logic [CNT_W-1:0] total_cnt;
  logic             overflow;
`ifdef DETECT_LOG_DROP_CNT_EN
  logic [CNT_W-1:0] drop_cnt;
`endif

  modport master (
    input  det,
    input  out_ready,
    output out_valid,
    output out_ts,
    output total_cnt,
`ifdef DETECT_LOG_DROP_CNT_EN
    output drop_cnt,
`endif
    output overflow
  );

  modport slave (
    output det,
    output out_ready,
    input  out_valid,
    input  out_ts,
    input  total_cnt,
`ifdef DETECT_LOG_DROP_CNT_EN
    input  drop_cnt,
`endif
    input  overflow
  );
endinterface

// File: rtl/detect_event_logger.sv
// Timestamping FIFO logger for detector pulses with saturating counters and sticky overflow.
// Optional saturating drop counter compiled in with DETECT_LOG_DROP_CNT_EN.
module detect_event_logger #(
  parameter int TS_W  = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input logic                  clk,
  input logic                  resetn,
  detect_event_logger_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_PARTIAL,
    ST_FULL
  } occState_t;

  occState_t        r_state;
  logic [TS_W-1:0]  r_ts;
  logic [TS_W-1:0]  r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [AW:0]      r_count;
  logic             r_outValid;
  logic [TS_W-1:0]  r_outTs;
  logic [CNT_W-1:0] r_totalCnt;
  logic             r_overflow;
`ifdef DETECT_LOG_DROP_CNT_EN
  logic [CNT_W-1:0] r_dropCnt;
`endif

  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [AW-1:0]    w_nextRd;
  logic [AW:0]      w_nextCount;
  logic [TS_W-1:0]  w_nextHead;
  occState_t        w_nextState;

  // The head for the next cycle may be the entry being written on this very edge.
  always_comb begin
    w_pop       = r_outValid & bus.out_ready;
    w_push      = bus.det & ((r_state != ST_FULL) | w_pop);
    w_drop      = bus.det & ~w_push;
    w_nextRd    = w_pop ? r_rdPtr + AW'(1) : r_rdPtr;
    w_nextCount = r_count;
    if (w_push && !w_pop) begin
      w_nextCount = r_count + (AW+1)'(1);
    end else if (w_pop && !w_push) begin
      w_nextCount = r_count - (AW+1)'(1);
    end
    w_nextHead = r_mem[w_nextRd];
    if (w_push && (r_wrPtr == w_nextRd)) begin
      w_nextHead = r_ts;
    end
    if (w_nextCount == '0) begin
      w_nextState = ST_EMPTY;
    end else if (w_nextCount == FULL_CNT) begin
      w_nextState = ST_FULL;
    end else begin
      w_nextState = ST_PARTIAL;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= ST_EMPTY;
      r_ts       <= '0;
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_outValid <= 1'b0;
      r_outTs    <= '0;
      r_totalCnt <= '0;
      r_overflow <= 1'b0;
`ifdef DETECT_LOG_DROP_CNT_EN
      r_dropCnt  <= '0;
`endif
    end else begin
      r_ts    <= r_ts + TS_W'(1);
      r_state <= w_nextState;
      r_count <= w_nextCount;
      r_rdPtr <= w_nextRd;
      if (w_push) begin
        r_mem[r_wrPtr] <= r_ts;
        r_wrPtr        <= r_wrPtr + AW'(1);
      end
      r_outValid <= (w_nextState != ST_EMPTY);
      if (w_nextState != ST_EMPTY) begin
        r_outTs <= w_nextHead;
      end
      if (bus.det && (r_totalCnt != '1)) begin
        r_totalCnt <= r_totalCnt + CNT_W'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
`ifdef DETECT_LOG_DROP_CNT_EN
      if (w_drop && (r_dropCnt != '1)) begin
        r_dropCnt <= r_dropCnt + CNT_W'(1);
      end
`endif
    end
  end

  assign bus.out_valid = r_outValid;
  assign bus.out_ts    = r_outTs;
  assign bus.total_cnt = r_totalCnt;
  assign bus.overflow  = r_overflow;
`ifdef DETECT_LOG_DROP_CNT_EN
  assign bus.drop_cnt  = r_dropCnt;
`endif
endmodule

// File: tb/tb_detect_event_logger.sv
// Self-checking bench for detect_event_logger: directed scenarios then long random traffic
// compared each cycle against a queue-based reference model.
module tb_detect_event_logger;
  localparam int TS_W  = 16;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int unsigned TS_MAX  = (1 << TS_W) - 1;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic resetn;

  detect_event_logger_if #(.TS_W(TS_W), .CNT_W(CNT_W)) bus ();

  detect_event_logger #(.TS_W(TS_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;

  // Reference model: a plain queue of timestamps plus arithmetic counters.
  int unsigned mQ[$];
  int unsigned mTs;
  int unsigned mTotal;
  int unsigned mDrop;
  bit          mOvf;
  bit          mAfterReset;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelStep(input logic d, input logic r, input logic rn);
    bit pop;
    if (!rn) begin
      mQ.delete();
      mTs = 0; mTotal = 0; mDrop = 0; mOvf = 0; mAfterReset = 1;
    end else begin
      pop = (mQ.size() > 0) && r;
      if (pop) void'(mQ.pop_front());
      if (d) begin
        if (mTotal < CNT_MAX) mTotal++;
        if (mQ.size() < DEPTH) begin
          mQ.push_back(mTs);
          mAfterReset = 0;
        end else begin
          mOvf = 1;
          if (mDrop < CNT_MAX) mDrop++;
        end
      end
      mTs = (mTs + 1) & TS_MAX;
    end
  endtask

  task automatic checkAll();
    checkOutput("out_valid", 32'(bus.out_valid), 32'(mQ.size() > 0));
    if (mQ.size() > 0)
      checkOutput("out_ts", 32'(bus.out_ts), mQ[0]);
    else if (mAfterReset)
      checkOutput("out_ts_rst", 32'(bus.out_ts), 32'd0);
    checkOutput("total_cnt", 32'(bus.total_cnt), mTotal);
    checkOutput("overflow", 32'(bus.overflow), 32'(mOvf));
`ifdef DETECT_LOG_DROP_CNT_EN
    checkOutput("drop_cnt", 32'(bus.drop_cnt), mDrop);
`endif
  endtask

  // Called just after a falling edge: drive, let one rising edge happen, check at next fall.
  task automatic applyStimulus(input logic d, input logic r, input logic rn);
    bus.det       = d;
    bus.out_ready = r;
    resetn        = rn;
    @(posedge clk);
    modelStep(d, r, rn);
    @(negedge clk);
    checkAll();
  endtask

  task automatic doReset();
    repeat (2) applyStimulus(1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    int pDet, pRdy, seg;
    bus.det = 1'b0;
    bus.out_ready = 1'b0;
    resetn = 1'b0;
    mQ.delete();
    mTs = 0; mTotal = 0; mDrop = 0; mOvf = 0; mAfterReset = 1;
    @(negedge clk);

    // First active edge logs timestamp 0
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("first_ts", 32'(bus.out_ts), 32'd0);
    checkOutput("first_total", 32'(bus.total_cnt), 32'd1);
    repeat (2) applyStimulus(1'b0, 1'b1, 1'b1);

    // Entries at 5, 7, 9 held, then drained in order
    doReset();
    while (mTs < 13) applyStimulus(mTs == 5 || mTs == 7 || mTs == 9, 1'b0, 1'b1);
    checkOutput("held_head", 32'(bus.out_ts), 32'd5);
    repeat (5) applyStimulus(1'b0, 1'b1, 1'b1);

    // Six back-to-back events into a four-deep queue
    doReset();
    while (mTs < 20) applyStimulus(mTs >= 10 && mTs <= 15, 1'b0, 1'b1);
    checkOutput("ovf_total", 32'(bus.total_cnt), 32'd6);
    checkOutput("ovf_flag", 32'(bus.overflow), 32'd1);
    repeat (6) applyStimulus(1'b0, 1'b1, 1'b1);

    // Full queue with same-edge push and pop must not overflow
    doReset();
    repeat (4) applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("full_pp_ovf", 32'(bus.overflow), 32'd0);
    repeat (6) applyStimulus(1'b0, 1'b1, 1'b1);

    // Reset with entries queued and overflow set
    doReset();
    repeat (6) applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("rst_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_ovf", 32'(bus.overflow), 32'd0);
    repeat (4) applyStimulus(1'b0, 1'b1, 1'b1);

    // Long random run without reset: covers timestamp wrap and count saturation
    doReset();
    for (int i = 0; i < 66000; i++) begin
      seg = (i / 1000) % 4;
      pDet = (seg == 0) ? 10 : (seg == 1) ? 50 : (seg == 2) ? 90 : 100;
      pRdy = (seg == 0) ? 90 : (seg == 1) ? 50 : (seg == 2) ? 20 : 70;
      applyStimulus($urandom_range(99) < pDet, $urandom_range(99) < pRdy, 1'b1);
    end

    // Random traffic with occasional mid-operation resets
    for (int i = 0; i < 1500; i++) begin
      applyStimulus($urandom_range(99) < 60, $urandom_range(99) < 40,
                    $urandom_range(199) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChecks, nFails);
    $finish;
  end
endmodule
